// File: rtl/reference_timestamper_mc_if.sv
// Decoupled timestamped-event stream: one (data, time, channel) beat per valid/ready fire.
interface reference_timestamper_mc_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIME_WIDTH = 64,
  parameter int unsigned CH_W       = 2
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] bits_data;
  logic [TIME_WIDTH-1:0] bits_time;
  logic [CH_W-1:0]       bits_channel;

  modport master (
    output valid, bits_data, bits_time, bits_channel,
    input  ready
  );

  modport slave (
    input  valid, bits_data, bits_time, bits_channel,
    output ready
  );
endinterface

// File: rtl/reference_timestamper_mc.sv
// Multi-channel transition timestamper: per-channel FIFOs of {value, cycle count}
// merged round-robin into a single decoupled event stream.
module reference_timestamper_mc #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned TIME_WIDTH   = 64,
  parameter int unsigned CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] value_i,
  reference_timestamper_mc_if.master         ts,
  output logic [NUM_CHANNELS-1:0]            overflow_o,
  output logic [31:0]                        drop_count_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned EntW  = DATA_WIDTH + TIME_WIDTH;
  localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

  logic [TIME_WIDTH-1:0] counter_q;
  logic                  primed_q;
  logic [DATA_WIDTH-1:0] prev_q   [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] chan_val [NUM_CHANNELS];
  logic [EntW-1:0]       mem_q    [NUM_CHANNELS][Depth];
  logic [PtrW-1:0]       wptr_q   [NUM_CHANNELS];
  logic [PtrW-1:0]       rptr_q   [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] push, pop, full, empty, wr_en, drop;
  logic [NUM_CHANNELS-1:0] overflow_q;
  logic [31:0]             drop_count_q, drop_count_d, drop_sum;
  logic [32:0]             drop_total;

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [TIME_WIDTH-1:0] time_q;
  logic [CH_W-1:0]       chan_q, last_grant_q, grant_idx, cand_idx;
  logic                  grant_found, load;
  logic [EntW-1:0]       head;

  assign load = !valid_q || ts.ready;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand_idx    = last_grant_q;
    for (int unsigned k = 1; k <= NUM_CHANNELS; k++) begin
      cand_idx = CH_W'((32'(last_grant_q) + k) % NUM_CHANNELS);
      if (!grant_found && !empty[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign head = mem_q[grant_idx][rptr_q[grant_idx][DEPTH_LOG2-1:0]];

  always_comb begin
    drop_sum = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      chan_val[c] = value_i[c*DATA_WIDTH +: DATA_WIDTH];
      empty[c]    = wptr_q[c] == rptr_q[c];
      full[c]     = PtrW'(wptr_q[c] - rptr_q[c]) == PtrW'(Depth);
      push[c]     = enable_i && (!primed_q || (chan_val[c] != prev_q[c]));
      pop[c]      = load && grant_found && (grant_idx == CH_W'(c));
      // A full FIFO still accepts when it is being popped in the same cycle.
      wr_en[c]    = push[c] && (!full[c] || pop[c]);
      drop[c]     = push[c] && full[c] && !pop[c];
      drop_sum    = drop_sum + 32'(drop[c]);
    end
    drop_total   = {1'b0, drop_count_q} + {1'b0, drop_sum};
    drop_count_d = drop_total[32] ? 32'hFFFF_FFFF : drop_total[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_q    <= '0;
      primed_q     <= 1'b0;
      overflow_q   <= '0;
      drop_count_q <= '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
    end else begin
      counter_q    <= counter_q + TIME_WIDTH'(1);
      overflow_q   <= overflow_q | drop;
      drop_count_q <= drop_count_d;
      if (enable_i) primed_q <= 1'b1;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        if (wr_en[c]) wptr_q[c] <= wptr_q[c] + PtrW'(1);
        if (pop[c])   rptr_q[c] <= rptr_q[c] + PtrW'(1);
      end
    end
  end

  // Storage and last-sample history need no reset; pointers and primed_q gate their use.
  always_ff @(posedge clk_i) begin
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      if (enable_i) prev_q[c] <= chan_val[c];
      if (wr_en[c]) mem_q[c][wptr_q[c][DEPTH_LOG2-1:0]] <= {chan_val[c], counter_q};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      time_q       <= '0;
      chan_q       <= '0;
      last_grant_q <= CH_W'(NUM_CHANNELS - 1);
    end else if (load) begin
      valid_q <= grant_found;
      if (grant_found) begin
        {data_q, time_q} <= head;
        chan_q           <= grant_idx;
        last_grant_q     <= grant_idx;
      end
    end
  end

  assign ts.valid        = valid_q;
  assign ts.bits_data    = data_q;
  assign ts.bits_time    = time_q;
  assign ts.bits_channel = chan_q;
  assign overflow_o      = overflow_q;
  assign drop_count_o    = drop_count_q;

endmodule
